// File: rtl/mips_pkg.sv
// Shared types and constants for the fetch unit
// of the single-cycle MIPS datapath.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC
  } fetch_state_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selection for the fetch unit:
// jr > j > taken beq > sequential.
module next_pc_logic
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] Instructions,
  input  logic [31:0] seOut,
  input  logic [31:0] reg_Da,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic        JumpReg,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] pc_plus4;
  logic        sel_jr;
  logic        sel_j;
  logic        sel_br;
  logic        unused_bits;

  assign pc_plus4 = pc + PC_INC;

  // One-hot selects so the decode below is truly unique
  assign sel_jr = JumpReg;
  assign sel_j  = Jump & ~JumpReg;
  assign sel_br = Branch & Zero & ~Jump & ~JumpReg;

  assign misalign = JumpReg & (reg_Da[1:0] != 2'b00);

  assign unused_bits = ^{Instructions[31:26], seOut[31:30]};

  always_comb begin
    next_pc = pc_plus4;
    unique case (1'b1)
      sel_jr:  next_pc = {reg_Da[31:2], 2'b00};
      sel_j:   next_pc = {pc_plus4[31:28],
                          Instructions[25:0], 2'b00};
      sel_br:  next_pc = pc_plus4 + {seOut[29:0], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, instruction register and
// IDLE/FETCH/EXEC handshake with a variable-latency imem.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instructions,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] seOut,
  input  logic [31:0] reg_Da,
  input  logic        stall,
  output logic        fetch_err
);

  localparam int CW =
    (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(MAX_WAIT - 1);

  fetch_state_t state;
  fetch_state_t state_nx;

  logic [31:0]   pc_q;
  logic [31:0]   ir_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic [31:0]   next_pc;
  logic          misalign;

  next_pc_logic u_next_pc (
    .pc           (pc_q),
    .Instructions (Instructions),
    .seOut        (seOut),
    .reg_Da       (reg_Da),
    .Branch       (Branch),
    .Zero         (Zero),
    .Jump         (Jump),
    .JumpReg      (JumpReg),
    .next_pc      (next_pc),
    .misalign     (misalign)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_FETCH: begin
          if (imem_ready) begin
            ir_q  <= imem_rdata;
            cnt_q <= '0;
          end else if (cnt_q == CNT_MAX) begin
            // Timeout is only reported; keep requesting
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            pc_q <= next_pc;
            if (misalign) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    Instructions = '0;
    unique case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_nx = S_EXEC;
      end
      S_EXEC: begin
        instr_valid  = 1'b1;
        Instructions = ir_q;
        if (!stall) state_nx = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected fetch
// addresses and words are queued and checked on output.
module tb_instr_fetch;

  localparam int          MW   = 16;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] W_J  = 32'h0800_0040;
  localparam logic [31:0] W_A  = 32'h2108_0001;
  localparam logic [31:0] W_B  = 32'h1000_FFFE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instructions;
  logic        instr_valid;
  logic [31:0] pc;
  logic        Branch, Zero, Jump, JumpReg;
  logic [31:0] seOut, reg_Da;
  logic        stall;
  logic        fetch_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_err;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_instr[$];

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC (RPC),
    .MAX_WAIT (MW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .Instructions (Instructions),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .Branch       (Branch),
    .Zero         (Zero),
    .Jump         (Jump),
    .JumpReg      (JumpReg),
    .seOut        (seOut),
    .reg_Da       (reg_Da),
    .stall        (stall),
    .fetch_err    (fetch_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h",
               tag, act, want);
    end
  endtask

  function automatic logic [31:0] model_npc(
    input logic [31:0] p, w, se, da,
    input logic b, z, j, jr);
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (jr)     return {da[31:2], 2'b00};
    if (j)      return {p4[31:28], w[25:0], 2'b00};
    if (b && z) return p4 + (se << 2);
    return p4;
  endfunction

  task automatic clr_ctl();
    Branch  = 1'b0;
    Zero    = 1'b0;
    Jump    = 1'b0;
    JumpReg = 1'b0;
    seOut   = '0;
    reg_Da  = '0;
    stall   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    clr_ctl();
    @(negedge clk);
    chk("rst_req",   imem_req,     0);
    chk("rst_valid", instr_valid,  0);
    chk("rst_instr", Instructions, 0);
    chk("rst_pc",    pc,           RPC);
    chk("rst_err",   fetch_err,    0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_err = 1'b0;
    exp_addr.delete();
    exp_instr.delete();
    exp_addr.push_back(RPC);
    @(negedge clk);
    chk("idle_to_fetch", imem_req, 1);
  endtask

  // Serve one fetch after dly low-ready cycles.
  // abort: check the address only, leave pending.
  task automatic do_fetch(input logic [31:0] w,
                          input int dly,
                          input bit abort);
    int n = 0;
    logic [31:0] a;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      chk("req_wait", imem_req, 1);
      return;
    end
    a = exp_addr.size() ? exp_addr.pop_front()
                        : 32'hx;
    chk("fetch_addr", imem_addr, a);
    if (abort) return;
    for (int i = 1; i <= dly; i++) begin
      imem_rdata = 32'hBAD0_0000 + i;
      @(negedge clk);
      chk("wait_req", imem_req, 1);
      if (i == MW - 1)
        chk("err_pre_to", fetch_err, exp_err);
      if (i == MW) begin
        exp_err = 1'b1;
        chk("err_to", fetch_err, 1);
      end
    end
    imem_ready = 1'b1;
    imem_rdata = w;
    exp_instr.push_back(w);
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic do_exec(input logic b, z, j, jr,
                         input logic [31:0] se, da,
                         input int stalls);
    logic [31:0] p0, w;
    w = exp_instr.size() ? exp_instr.pop_front()
                         : 32'hx;
    chk("exec_valid", instr_valid, 1);
    chk("exec_instr", Instructions, w);
    chk("exec_req",   imem_req, 0);
    p0      = pc;
    Branch  = b;
    Zero    = z;
    Jump    = j;
    JumpReg = jr;
    seOut   = se;
    reg_Da  = da;
    for (int i = 0; i < stalls; i++) begin
      stall      = 1'b1;
      imem_ready = 1'b1;
      imem_rdata = 32'h5A5A_0000 + i;
      @(negedge clk);
      chk("stall_valid", instr_valid, 1);
      chk("stall_pc",    pc, p0);
      chk("stall_instr", Instructions, w);
    end
    imem_ready = 1'b0;
    stall      = 1'b0;
    if (jr && da[1:0] != 2'b00) exp_err = 1'b1;
    exp_addr.push_back(
      model_npc(p0, w, se, da, b, z, j, jr));
    @(negedge clk);
    clr_ctl();
    chk("exec_err", fetch_err, exp_err);
    chk("post_valid", instr_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  initial begin
    exp_err = 1'b0;
    do_reset();
    do_fetch(W_A, 0, 0);
    do_exec(0, 0, 0, 0, 0, 0, 0);
    do_fetch(W_J, 0, 0);
    do_exec(0, 0, 1, 0, 0, 0, 0);
    do_fetch(W_B, 1, 0);
    do_exec(1, 1, 0, 0, 32'hFFFF_FFFE, 0, 0);
    do_fetch(W_J, 2, 0);
    do_exec(0, 0, 1, 0, 0, 0, 0);
    do_fetch(W_B, 0, 0);
    do_exec(1, 0, 0, 0, 32'hFFFF_FFFE, 0, 0);
    do_fetch(W_A, 0, 0);
    do_exec(0, 0, 0, 1, 0, 32'hF000_0010, 0);
    do_fetch(W_J, 0, 0);
    do_exec(0, 0, 1, 0, 0, 0, 0);
    do_fetch(W_J, 0, 0);
    do_exec(0, 0, 1, 1, 0, 32'h0000_0200, 0);
    do_fetch(W_A, 0, 0);
    do_exec(0, 0, 0, 1, 0, 32'h0000_0203, 0);
    do_fetch(W_A, 0, 0);
    do_exec(1, 1, 0, 0, 32'h0000_0010, 0, 3);
    do_fetch(W_A, 0, 0);
    do_exec(1, 0, 0, 0, 32'h8000_0000, 0, 0);
    do_reset();
    do_fetch(W_B, MW + 2, 0);
    do_exec(0, 0, 0, 0, 0, 0, 2);
    do_fetch(W_A, 0, 1);
    do_reset();
    do_fetch(W_A, 0, 0);
    do_reset();
    do_fetch(W_B, 0, 0);
    do_exec(1, 1, 0, 0, 32'hFFFF_FFFF, 0, 0);
    do_fetch(W_A, 0, 1);
    chk("final_err", fetch_err, 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
